// File: rtl/sr_pkg.sv
// Shared definitions for the SR latch driver: FSM state encoding, default
// timing windows and the cycle-counter width helper.
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_e;

    localparam int PULSE_CYC_DEF  = 2;
    localparam int SETTLE_CYC_DEF = 2;

    // One spare bit keeps the reload value representable for any window length.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// Parameterised-width two-flop synchroniser for signals asynchronous to clk_i.
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture chain, cleared by synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Drives a bank of gated SR latches with timed, mutually exclusive S/R pulses
// derived from the target value and synchronised Q feedback, then verifies Q.
module sr_latch_driver
    import sr_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int PULSE_CYC  = PULSE_CYC_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] Q_fb,
    output logic             done,
    output logic [WIDTH-1:0] err
);

    localparam int            CW          = cnt_width(PULSE_CYC, SETTLE_CYC);
    localparam logic [CW-1:0] PULSE_LOAD  = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] err_q, err_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] q_sync_s;
    logic             accept_s;

    sync2 #(.WIDTH(WIDTH)) u_sync_q (
        .clk_i (Clk),
        .rst_i (Rst),
        .d_i   (Q_fb),
        .q_o   (q_sync_s)
    );

    assign req_ready = (state_q == IDLE) && !Rst;
    assign accept_s  = req_valid && req_ready;

    // Next-state, counter and excitation logic; S and R are built from
    // disjoint masks so they can never be high together on one bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        s_d      = s_q;
        r_d      = r_q;
        err_d    = err_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    target_d = req_data;
                    err_d    = '0;
                    s_d      = req_data & ~q_sync_s;
                    r_d      = ~req_data & q_sync_s;
                    if (|((req_data & ~q_sync_s) | (~req_data & q_sync_s))) begin
                        state_d = PULSE;
                        cnt_d   = PULSE_LOAD;
                    end else begin
                        state_d = CHECK;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    s_d     = '0;
                    r_d     = '0;
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            SETTLE: begin
                // Only the last settle-cycle sample decides the readback result.
                if (cnt_q == '0) begin
                    err_d   = q_sync_s ^ target_q;
                    state_d = CHECK;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            CHECK: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                s_d     = '0;
                r_d     = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= '0;
            s_q      <= '0;
            r_q      <= '0;
            err_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            s_q      <= s_d;
            r_q      <= r_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign S    = s_q;
    assign R    = r_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: doc/sr_latch_driver.md
# sr_latch_driver

Synchronous initiator for a bank of gated SR latches: accepts a target bit-vector over a valid/ready handshake, derives per-bit set/reset excitation from the latch's current output, and pulses S/R for a fixed window. It then waits a settle window and reads back Q to confirm the write, reporting done/err. It sits between clocked control logic and the gate-level SR latch/flip-flop cells, so those cells are only driven with legal, timed S/R patterns.

## Interface
- WIDTH, 4: number of latch bits driven.
- PULSE_CYC, 2: cycles S/R are held asserted (>=1).
- SETTLE_CYC, 2: cycles with S=R=0 before readback (>=2, covers feedback synchroniser).
- Clk  in  1  sole clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- req_valid  in  1  target write request.
- req_ready  out  1  high only in IDLE and Rst low.
- req_data  in  WIDTH  target latch value, sampled on accept.
- S  out  WIDTH  set drive to latch bank, registered.
- R  out  WIDTH  reset drive to latch bank, registered.
- Q_fb  in  WIDTH  latch Q outputs, asynchronous to Clk.
- done  out  1  one-cycle completion strobe.
- err  out  WIDTH  per-bit readback mismatch, valid while done high, held until next accept.

## Operation
- Q_fb passes through a 2-flop synchroniser; q_sync is the only feedback used.
- Accept = req_valid & req_ready at a rising edge; target <= req_data; S <= target & ~q_sync; R <= ~target & q_sync.
- Bits already matching get S=R=0. S&R must never be 1 on any bit, in any cycle.
- States:
  - IDLE: accept -> PULSE if (S|R) nonzero; else -> CHECK with err <= 0.
  - PULSE: hold S/R for PULSE_CYC cycles; on exit S<=0, R<=0 -> SETTLE.
  - SETTLE: SETTLE_CYC cycles; on final cycle err <= q_sync ^ target -> CHECK.
  - CHECK: exactly one cycle, done=1 -> IDLE.
- A cycle counter (width clog2(max(PULSE_CYC,SETTLE_CYC))+1) reloads on each state entry.
- err is cleared on every accept.
- req_valid while not ready is ignored; req_data is not sampled.

## Timing
- Reset values: state=IDLE, S=0, R=0, done=0, err=0, counter=0, synchroniser=0, target=0. req_ready=0 while Rst high, 1 the first cycle after.
- Accept at edge k: S/R valid cycles k+1 .. k+PULSE_CYC. SETTLE follows for SETTLE_CYC cycles, then done=1 in cycle k+PULSE_CYC+SETTLE_CYC+1 (default: 5 cycles after accept).
- No-change request: done=1 in cycle k+1, S/R never asserted.
- req_ready returns high the cycle after done, so back-to-back throughput is one request per PULSE_CYC+SETTLE_CYC+2 cycles. A req_valid held high is accepted the cycle after done.
- Rst mid-operation: S/R forced 0 at that edge, no done issued, pending request dropped.
- Q_fb changes during PULSE/SETTLE are tolerated. Only the final SETTLE-cycle sample decides err.

## Structure
- Shared package sr_pkg holds:
  - state encoding constants (IDLE, PULSE, SETTLE, CHECK);
  - PULSE_CYC/SETTLE_CYC default constants.
- One sub-module: sync2, a parameterised-width two-flop synchroniser, instantiated on Q_fb.
- FSM, counter, excitation logic, and err register live in sr_latch_driver.

## Test plan
- Reset then idle, Q_fb=0000: S=R=0000, done=0, err=0000, req_ready=1 after Rst falls.
- Q_fb=0000, write 1010 with a behavioural latch model: S=1010, R=0000 for 2 cycles. Then done=1 at cycle k+5, err=0000, Q_fb=1010.
- Q_fb=1111, write 0101: S=0000, R=1010 for 2 cycles, never S&R. done at k+5, err=0000.
- Q_fb=0110, write 0110: no S/R activity. done at k+1, err=0000.
- Latch model with bit 2 stuck at 0, write 0100: S=0100 pulse, then done with err=0100. err holds 0100 until next accept.
- Assert Rst during PULSE cycle 1: S/R=0 next cycle, no done. A new request after reset completes normally with a fresh err.
